// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM burst sequencer.
package sram_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        WR_WAIT  = 3'd4
    } state_t;

    // Burst length field: 0 stands for a full 256-word burst.
    function automatic logic [8:0] decode_len(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/sram_rd_fifo.sv
// Read-return FIFO between the SRAM controller and the rdata stream.
// A push while full is accepted only when a pop happens in the same cycle.
module sram_rd_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage: contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; reset flushes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_burst_sequencer.sv
// Splits read/write bursts into single-word SRAM controller commands,
// one outstanding at a time, with a per-command completion timeout.
//
// state    | meaning
// ---------|---------------------------------------------------------
// IDLE     | waiting for a burst request (req_ready high)
// RD_ISSUE | next read is issued as soon as the return FIFO has room
// RD_WAIT  | ctl_read_en held until ctl_read_valid or timeout
// WR_ISSUE | waiting for the next write word (wdata_ready high)
// WR_WAIT  | ctl_wr_en held until ctl_wr_valid or timeout
module sram_burst_sequencer #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              ctl_read_en,
    output logic              ctl_wr_en,
    output logic [ADDR_W-1:0] ctl_address,
    output logic [DATA_W-1:0] ctl_wr_data,
    input  logic              ctl_read_valid,
    input  logic              ctl_wr_valid,
    input  logic [DATA_W-1:0] ctl_read_data,
    output logic              busy,
    output logic              err
);

    import sram_pkg::*;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic [8:0]        remain;
    logic [8:0]        remain_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic [ADDR_W-1:0] ctl_address_nxt;
    logic [DATA_W-1:0] ctl_wr_data_nxt;
    logic              err_nxt;
    logic              wait_expired;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    // Command enables are pure state decodes, so reset kills them at once.
    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign wdata_ready = (state == WR_ISSUE);
    assign ctl_read_en = (state == RD_WAIT);
    assign ctl_wr_en   = (state == WR_WAIT);
    assign rdata_valid = !fifo_empty;
    assign fifo_pop    = rdata_valid && rdata_ready;

    // The counter would reach TIMEOUT on this edge.
    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // Next-state, address/count advance and command register updates.
    always_comb begin
        state_nxt       = state;
        addr_nxt        = addr;
        remain_nxt      = remain;
        wait_cnt_nxt    = wait_cnt;
        ctl_address_nxt = ctl_address;
        ctl_wr_data_nxt = ctl_wr_data;
        err_nxt         = err;
        fifo_push       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_nxt   = req_addr;
                    remain_nxt = decode_len(req_len);
                    state_nxt  = req_write ? WR_ISSUE : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (!fifo_full) begin
                    ctl_address_nxt = addr;
                    wait_cnt_nxt    = '0;
                    state_nxt       = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (ctl_read_valid) begin
                    fifo_push  = 1'b1;
                    addr_nxt   = addr + 1'b1;
                    remain_nxt = remain - 1'b1;
                    state_nxt  = (remain == 9'd1) ? IDLE : RD_ISSUE;
                end else if (wait_expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            WR_ISSUE: begin
                if (wdata_valid) begin
                    ctl_wr_data_nxt = wdata;
                    ctl_address_nxt = addr;
                    wait_cnt_nxt    = '0;
                    state_nxt       = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (ctl_wr_valid) begin
                    addr_nxt   = addr + 1'b1;
                    remain_nxt = remain - 1'b1;
                    state_nxt  = (remain == 9'd1) ? IDLE : WR_ISSUE;
                end else if (wait_expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, burst bookkeeping and controller command registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            remain      <= '0;
            wait_cnt    <= '0;
            ctl_address <= '0;
            ctl_wr_data <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            addr        <= addr_nxt;
            remain      <= remain_nxt;
            wait_cnt    <= wait_cnt_nxt;
            ctl_address <= ctl_address_nxt;
            ctl_wr_data <= ctl_wr_data_nxt;
            err         <= err_nxt;
        end
    end

    sram_rd_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (ctl_read_data),
        .pop       (fifo_pop),
        .pop_data  (rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_sram_burst_sequencer.sv
// Directed bench for sram_burst_sequencer: a burst-level model predicts the
// controller command stream and read-return stream; a monitor compares them.
module tb_sram_burst_sequencer;

    typedef struct {
        bit          wr;
        logic [17:0] addr;
        logic [15:0] data;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [17:0] req_addr;
    logic [7:0]  req_len;
    logic        wdata_valid, wdata_ready;
    logic [15:0] wdata;
    logic        rdata_valid, rdata_ready;
    logic [15:0] rdata;
    logic        ctl_read_en, ctl_wr_en;
    logic [17:0] ctl_address;
    logic [15:0] ctl_wr_data;
    logic        ctl_read_valid, ctl_wr_valid;
    logic [15:0] ctl_read_data;
    logic        busy, err;

    int   n_vec = 0;
    int   n_bad = 0;
    cmd_t exp_cmd[$];
    logic [15:0] exp_rd[$];
    logic [17:0] cmd_log[$];
    int   cmd_count = 0;
    int   rd_en_cycles = 0;
    bit   respond_en = 1'b1;
    bit   stray = 1'b0;

    sram_burst_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .wdata_valid    (wdata_valid),
        .wdata_ready    (wdata_ready),
        .wdata          (wdata),
        .rdata_valid    (rdata_valid),
        .rdata_ready    (rdata_ready),
        .rdata          (rdata),
        .ctl_read_en    (ctl_read_en),
        .ctl_wr_en      (ctl_wr_en),
        .ctl_address    (ctl_address),
        .ctl_wr_data    (ctl_wr_data),
        .ctl_read_valid (ctl_read_valid),
        .ctl_wr_valid   (ctl_wr_valid),
        .ctl_read_data  (ctl_read_data),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got %0h, required nothing", name, act);
    endtask

    // Controller's read data is a fixed function of the address.
    function automatic logic [15:0] ret_of(input logic [17:0] a);
        logic [17:0] d;
        d = a - 18'h0000F;
        return {4'hA, d[11:0]};
    endfunction

    // Model: burst expands into len words at consecutive addresses mod 2^18.
    task automatic expect_read(input int unsigned a, input int unsigned n_words, input int unsigned n_done);
        for (int i = 0; i < n_words; i++) begin
            cmd_t c;
            c.wr   = 1'b0;
            c.addr = 18'((a + i) % 262144);
            c.data = 16'h0;
            exp_cmd.push_back(c);
            if (i < n_done) exp_rd.push_back(ret_of(c.addr));
        end
    endtask

    task automatic expect_write(input int unsigned a, input logic [15:0] d);
        cmd_t c;
        c.wr   = 1'b1;
        c.addr = 18'(a % 262144);
        c.data = d;
        exp_cmd.push_back(c);
    endtask

    // Controller responder: completes each command one cycle after it appears.
    initial begin
        bit rd_v, wr_v;
        rd_v = 1'b0;
        wr_v = 1'b0;
        ctl_read_valid = 1'b0;
        ctl_wr_valid   = 1'b0;
        ctl_read_data  = 16'h0;
        forever begin
            @(negedge clk);
            rd_v = respond_en && ctl_read_en && !rd_v;
            wr_v = respond_en && ctl_wr_en && !wr_v;
            if (rd_v) ctl_read_data = ret_of(ctl_address);
            ctl_read_valid = rd_v || stray;
            ctl_wr_valid   = wr_v || stray;
        end
    end

    // Monitor: compares every command and every returned word with the model.
    initial begin
        bit          prev_rd, prev_wr;
        logic [17:0] cur_addr;
        logic [15:0] cur_data;
        prev_rd  = 1'b0;
        prev_wr  = 1'b0;
        cur_addr = '0;
        cur_data = '0;
        forever begin
            @(negedge clk);
            check("en_exclusive", 32'(ctl_read_en & ctl_wr_en), 32'd0);
            check("busy_vs_ready", 32'(busy), 32'(!req_ready));
            if (ctl_read_en) rd_en_cycles++;
            if ((ctl_read_en && !prev_rd) || (ctl_wr_en && !prev_wr)) begin
                if (exp_cmd.size() == 0) begin
                    unexpected("cmd", 32'(ctl_address));
                end else begin
                    cmd_t c;
                    c = exp_cmd.pop_front();
                    check("cmd_dir", 32'(ctl_wr_en), 32'(c.wr));
                    check("cmd_addr", 32'(ctl_address), 32'(c.addr));
                    if (c.wr) check("cmd_wdata", 32'(ctl_wr_data), 32'(c.data));
                end
                cur_addr = ctl_address;
                cur_data = ctl_wr_data;
                cmd_log.push_back(ctl_address);
                cmd_count++;
            end else if (ctl_read_en || ctl_wr_en) begin
                check("cmd_addr_hold", 32'(ctl_address), 32'(cur_addr));
                if (ctl_wr_en) check("cmd_wdata_hold", 32'(ctl_wr_data), 32'(cur_data));
            end
            if (rdata_valid && rdata_ready) begin
                if (exp_rd.size() == 0) unexpected("rdata", 32'(rdata));
                else check("rdata", 32'(rdata), 32'(exp_rd.pop_front()));
            end
            prev_rd = ctl_read_en;
            prev_wr = ctl_wr_en;
        end
    end

    task automatic send_req(input bit wr, input int unsigned a, input int unsigned len);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = 18'(a);
        req_len   = 8'(len);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic send_wdata(input logic [15:0] d);
        int n;
        wdata       = d;
        wdata_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wdata_ready && n < 300);
        check("wdata_handshake", 32'(wdata_ready), 32'd1);
        @(posedge clk); #1;
        wdata_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < bound);
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        int mark, mark_en;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_ctl_address", 32'(ctl_address), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Read burst, len 3 at 0x00010.
        mark = cmd_count;
        expect_read(32'h10, 3, 3);
        send_req(1'b0, 32'h10, 3);
        wait_idle("rd3_done", 100);
        check("rd3_rdata_at_busy_fall", 32'(rdata), 32'hA003);
        check("rd3_rvalid_at_busy_fall", 32'(rdata_valid), 32'd1);
        check("rd3_addr0", 32'(cmd_log[mark]), 32'h10);
        check("rd3_addr2", 32'(cmd_log[mark + 2]), 32'h12);
        repeat (3) @(negedge clk);
        check("rd3_drained", 32'(exp_rd.size()), 32'd0);

        // Write burst, len 3 at 0x3FFFE, wraps to 0.
        mark = cmd_count;
        expect_write(32'h3FFFE, 16'h1111);
        expect_write(32'h3FFFF, 16'h2222);
        expect_write(32'h40000, 16'h3333);
        send_req(1'b1, 32'h3FFFE, 3);
        send_wdata(16'h1111);
        send_wdata(16'h2222);
        send_wdata(16'h3333);
        wait_idle("wr3_done", 100);
        check("wr3_count", 32'(cmd_count - mark), 32'd3);
        check("wr3_addr1", 32'(cmd_log[mark + 1]), 32'h3FFFF);
        check("wr3_addr_wrap", 32'(cmd_log[mark + 2]), 32'h0);

        // Stray completions while idle are ignored.
        mark = cmd_count;
        @(posedge clk); #1; stray = 1'b1;
        repeat (2) @(posedge clk);
        #1; stray = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_rvalid", 32'(rdata_valid), 32'd0);
        check("stray_cmds", 32'(cmd_count - mark), 32'd0);

        // Backpressure: FIFO of 4 fills, then the sequencer stalls.
        mark = cmd_count;
        rdata_ready = 1'b0;
        expect_read(32'h200, 8, 8);
        send_req(1'b0, 32'h200, 8);
        repeat (40) @(negedge clk);
        check("bp_issued", 32'(cmd_count - mark), 32'd4);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_read_en", 32'(ctl_read_en), 32'd0);
        @(posedge clk); #1; rdata_ready = 1'b1;
        wait_idle("bp_done", 300);
        repeat (6) @(negedge clk);
        check("bp_issued_all", 32'(cmd_count - mark), 32'd8);
        check("bp_rd_left", 32'(exp_rd.size()), 32'd0);
        check("bp_rvalid_end", 32'(rdata_valid), 32'd0);

        // len 0 = 256 words at 0x00100.
        mark = cmd_count;
        expect_read(32'h100, 256, 256);
        send_req(1'b0, 32'h100, 0);
        wait_idle("len0_done", 3000);
        repeat (3) @(negedge clk);
        check("len0_count", 32'(cmd_count - mark), 32'd256);
        check("len0_first", 32'(cmd_log[mark]), 32'h100);
        check("len0_last", 32'(cmd_log[mark + 255]), 32'h1FF);
        check("len0_rd_left", 32'(exp_rd.size()), 32'd0);

        // Timeout: controller never answers.
        check("to_err_before", 32'(err), 32'd0);
        respond_en = 1'b0;
        mark = cmd_count;
        mark_en = rd_en_cycles;
        expect_read(32'h300, 1, 0);
        send_req(1'b0, 32'h300, 2);
        wait_idle("to_idle", 600);
        check("to_wait_cycles", 32'(rd_en_cycles - mark_en), 32'd255);
        check("to_err", 32'(err), 32'd1);
        repeat (20) @(negedge clk);
        check("to_no_more_cmds", 32'(cmd_count - mark), 32'd1);
        check("to_err_sticky", 32'(err), 32'd1);

        // Reset in WR_WAIT of a len-4 write.
        expect_write(32'h00040, 16'hBEEF);
        send_req(1'b1, 32'h40, 4);
        send_wdata(16'hBEEF);
        repeat (5) @(negedge clk);
        check("rw_in_wait", 32'(ctl_wr_en), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rw_wr_en", 32'(ctl_wr_en), 32'd0);
        check("rw_read_en", 32'(ctl_read_en), 32'd0);
        check("rw_address", 32'(ctl_address), 32'd0);
        check("rw_wr_data", 32'(ctl_wr_data), 32'd0);
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_req_ready", 32'(req_ready), 32'd1);
        check("rw_wdata_ready", 32'(wdata_ready), 32'd0);
        check("rw_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        respond_en = 1'b1;
        mark = cmd_count;
        expect_read(32'h20, 1, 1);
        send_req(1'b0, 32'h20, 1);
        wait_idle("rw_read_done", 100);
        repeat (3) @(negedge clk);
        check("rw_read_cmds", 32'(cmd_count - mark), 32'd1);
        check("rw_rd_left", 32'(exp_rd.size()), 32'd0);
        check("rw_cmd_left", 32'(exp_cmd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_burst_sequencer.md
SRAM_BURST_SEQUENCER -- requirements
Module: sram_burst_sequencer

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 18, word address width; DATA_W, default 16, word width; FIFO_DEPTH, default 4, read-return FIFO entries; TIMEOUT, default 255, maximum wait cycles for one controller completion.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset; no other clock or reset SHALL exist.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid / req_ready  in / out  1 / 1  burst request handshake.
REQ-006 req_write  in  1  burst direction: 1 = write, 0 = read.
REQ-007 req_addr  in  ADDR_W  start word address.
REQ-008 req_len  in  8  burst length in words; 0 encodes 256.
REQ-009 wdata_valid / wdata_ready / wdata  in / out / in  1 / 1 / DATA_W  write-data stream.
REQ-010 rdata_valid / rdata_ready / rdata  out / in / out  1 / 1 / DATA_W  read-return stream.
REQ-011 ctl_read_en / ctl_wr_en / ctl_address / ctl_wr_data  out  1 / 1 / ADDR_W / DATA_W  command to the SRAM controller.
REQ-012 ctl_read_valid / ctl_wr_valid / ctl_read_data  in  1 / 1 / DATA_W  completion from the SRAM controller.
REQ-013 busy / err  out  1 / 1  burst in progress / sticky timeout flag.

Function
REQ-014 The state machine SHALL have these states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT.
REQ-015 req_ready SHALL be 1 exactly when the state is IDLE.
REQ-016 On req_valid and req_ready, the block SHALL latch the address, direction and remaining count (req_len, with 0 giving 256), then enter RD_ISSUE or WR_ISSUE on the next cycle.
REQ-017 RD_ISSUE: when the FIFO is not full, the block SHALL assert ctl_read_en with ctl_address equal to the current address, then enter RD_WAIT; when the FIFO is full, it SHALL stall in RD_ISSUE with ctl_read_en at 0.
REQ-018 RD_WAIT: the block SHALL hold ctl_read_en and ctl_address stable until ctl_read_valid is 1.
REQ-019 On that cycle, the block SHALL push ctl_read_data into the FIFO, deassert ctl_read_en the next cycle, increment the address, and decrement the remaining count.
REQ-020 After that cycle, the next state SHALL be IDLE if the remaining count reached 0, otherwise RD_ISSUE.
REQ-021 At most one read SHALL be outstanding at the controller.
REQ-022 WR_ISSUE: wdata_ready SHALL be 1 only in WR_ISSUE.
REQ-023 On the wdata handshake, the block SHALL register wdata onto ctl_wr_data, assert ctl_wr_en and ctl_address, and enter WR_WAIT.
REQ-024 WR_WAIT: the block SHALL hold ctl_wr_en, ctl_address and ctl_wr_data until ctl_wr_valid is 1, then advance the address and count with the same rules as REQ-019 and REQ-020, using WR_ISSUE instead of RD_ISSUE.
REQ-025 ctl_read_en and ctl_wr_en SHALL never both be 1.
REQ-026 Address increments SHALL be modulo 2^ADDR_W (2^18-1 wraps to 0).
REQ-027 The FIFO SHALL present rdata_valid whenever it is non-empty and pop on rdata_valid and rdata_ready.
REQ-028 A simultaneous push and pop SHALL leave the occupancy unchanged, and this SHALL be legal when the FIFO is full.
REQ-029 Read latency: rdata_valid SHALL rise 1 cycle after the ctl_read_valid that pushes into an empty FIFO.
REQ-030 A wait counter SHALL clear on entry to RD_WAIT or WR_WAIT and increment each cycle in those states.
REQ-031 When the wait counter reaches TIMEOUT, the block SHALL set err, deassert all ctl_* enables, discard the remaining burst, and return to IDLE; FIFO contents SHALL be kept.
REQ-032 err SHALL clear only on reset.
REQ-033 busy SHALL be 1 exactly when the state is not IDLE.
REQ-034 A ctl_read_valid or ctl_wr_valid that arrives outside the matching WAIT state SHALL be ignored.

Reset
REQ-035 Asserting rst SHALL, immediately and asynchronously, set the state to IDLE, clear the FIFO pointers, counters and err, and drive ctl_read_en, ctl_wr_en, wdata_ready, rdata_valid and busy to 0.
REQ-036 Reset mid-burst SHALL abandon the burst and flush the FIFO without emitting further ctl_* commands.
REQ-037 ctl_address and ctl_wr_data SHALL reset to 0.
REQ-038 req_ready SHALL read 1 while in IDLE, including during reset.

Structure
REQ-039 The state enum, ADDR_W, DATA_W and the len-0-means-256 decode function SHALL live in the shared package sram_pkg.
REQ-040 The read-return FIFO SHALL be a single sub-module, sram_rd_fifo, parameterised by DATA_W and FIFO_DEPTH, with full and empty outputs.
REQ-041 The top level SHALL contain the FSM, address and count registers, and the wait counter.

Verification
REQ-042 Read burst: addr 0x00010, len 3, controller returns 0xA001/0xA002/0xA003 one cycle after each read_en, rdata_ready held at 1 -> ctl_address 0x00010, 0x00011, 0x00012 and rdata in that order; busy falls after the third word.
REQ-043 Write burst: addr 0x3FFFE, len 3, data 0x1111/0x2222/0x3333 -> writes go to 0x3FFFE, 0x3FFFF, 0x00000 (wrap), one ctl_wr_en per word.
REQ-044 Backpressure: read len 8 with rdata_ready at 0 -> exactly 4 reads are issued, then the block stalls in RD_ISSUE; raising rdata_ready completes all 8 words in order with no loss.
REQ-045 Timeout: read len 2 with the controller never asserting valid -> err is 1 after 255 WAIT cycles, the state returns to IDLE, and no further read_en is issued.
REQ-046 Reset mid-write: rst asserted in WR_WAIT of a len-4 burst -> all outputs reach reset values in the same cycle, and a subsequent len-1 read completes normally.
REQ-047 len 0: read at addr 0x00100 -> 256 reads issued to 0x00100 through 0x001FF.
